// File: rtl/lector_7segmentos.sv
// lector_7segmentos
//   Reads back a multiplexed, active-low 7-segment display bus and recovers
//   the hex nibble shown on each digit. It samples seg/anode through a
//   2-flop synchronizer and only commits a digit after the {an, seg} sample
//   has been stable for STABLE_CYC cycles, once per anode window. Illegal
//   patterns and long anode conflicts raise sticky error flags.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   seg_i        segments a..g (bit6..bit0), active-low
//   an_i         anode enables, active-low, bit k selects digit k
//   clr_i        synchronous clear of digits, valid, errors, frame tracking
//   digits_o     recovered nibbles, digit k at [4k+3:4k]
//   valid_o      digit k holds a decoded hex value
//   frame_done_o one-cycle pulse when every digit has committed
//   err_o        sticky error (OR of err_code_o)
//   err_code_o   bit0 illegal pattern, bit1 anode conflict
module lector_7segmentos #(
    parameter int N_DIG      = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           seg_i,
    input  logic [N_DIG-1:0]     an_i,
    input  logic                 clr_i,
    output logic [4*N_DIG-1:0]   digits_o,
    output logic [N_DIG-1:0]     valid_o,
    output logic                 frame_done_o,
    output logic                 err_o,
    output logic [1:0]           err_code_o
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);

    typedef enum logic [1:0] {
        CLS_IDLE,
        CLS_SELECT,
        CLS_CONFLICT
    } sample_cls_e;

    // Returns {legal, nibble}; legal=0 for blank and for unknown patterns.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b0000001: r = 5'h10;
            7'b1001111: r = 5'h11;
            7'b0010010: r = 5'h12;
            7'b0000110: r = 5'h13;
            7'b1001100: r = 5'h14;
            7'b0100100: r = 5'h15;
            7'b0100000: r = 5'h16;
            7'b0001111: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0000100: r = 5'h19;
            7'b0001000: r = 5'h1A;
            7'b1100000: r = 5'h1B;
            7'b0110001: r = 5'h1C;
            7'b1000010: r = 5'h1D;
            7'b0110000: r = 5'h1E;
            7'b0111000: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    logic [6:0]         seg_s1_q, seg_s2_q;
    logic [N_DIG-1:0]   an_s1_q, an_s2_q;
    logic [N_DIG+6:0]   prev_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      conf_cnt_q, conf_cnt_d;
    logic               armed_q, armed_d;
    logic [N_DIG-1:0]   mask_q, mask_d;
    logic [4*N_DIG-1:0] digits_q, digits_d;
    logic [N_DIG-1:0]   valid_q, valid_d;
    logic               frame_q, frame_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               err_q, err_d;

    logic [N_DIG-1:0]   an_low;
    logic [N_DIG+6:0]   sample;
    logic               same;
    sample_cls_e        cls;
    logic [IW-1:0]      idx;
    logic [CW-1:0]      cnt_inc;
    logic               commit;
    logic [4:0]         dec;
    logic [N_DIG-1:0]   mask_nxt;

    always_comb begin
        an_low = ~an_s2_q;
        sample = {an_s2_q, seg_s2_q};
        same   = (sample == prev_q);

        if (an_low == '0) begin
            cls = CLS_IDLE;
        end else if ((an_low & (an_low - 1'b1)) == '0) begin
            cls = CLS_SELECT;
        end else begin
            cls = CLS_CONFLICT;
        end

        // OR-ing indices of low bits gives the index directly for a
        // one-hot-low select; the result is ignored for other classes.
        idx = '0;
        for (int unsigned k = 0; k < N_DIG; k++) begin
            if (an_low[k]) begin
                idx = idx | IW'(k);
            end
        end

        dec = decode_seg(seg_s2_q);

        digits_d   = digits_q;
        valid_d    = valid_q;
        err_code_d = err_code_q;
        mask_d     = mask_q;
        frame_d    = 1'b0;
        armed_d    = armed_q;
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        commit     = 1'b0;
        mask_nxt   = mask_q;

        if (same && cls == CLS_SELECT) begin
            cnt_d = cnt_inc;
            if (armed_q && cnt_inc == CNT_MAX) begin
                commit  = 1'b1;
                armed_d = 1'b0;
            end
        end else begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end

        if (cls == CLS_CONFLICT) begin
            conf_cnt_d = (conf_cnt_q == CNT_MAX) ? conf_cnt_q : conf_cnt_q + 1'b1;
        end else begin
            conf_cnt_d = '0;
        end
        if (conf_cnt_d == CNT_MAX) begin
            err_code_d[1] = 1'b1;
        end

        if (commit) begin
            if (dec[4]) begin
                digits_d[idx*4 +: 4] = dec[3:0];
                valid_d[idx]         = 1'b1;
            end else if (seg_s2_q == 7'h7F) begin
                digits_d[idx*4 +: 4] = 4'h0;
                valid_d[idx]         = 1'b0;
            end else begin
                valid_d[idx]  = 1'b0;
                err_code_d[0] = 1'b1;
            end
            mask_nxt = mask_q | an_low;
            if (mask_nxt == '1) begin
                frame_d = 1'b1;
                mask_d  = '0;
            end else begin
                mask_d = mask_nxt;
            end
        end

        // Clear overrides everything above, including a commit due this edge.
        if (clr_i) begin
            digits_d   = '0;
            valid_d    = '0;
            err_code_d = '0;
            mask_d     = '0;
            frame_d    = 1'b0;
            cnt_d      = '0;
            conf_cnt_d = '0;
            armed_d    = 1'b1;
        end

        err_d = |err_code_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q   <= 7'h7F;
            seg_s2_q   <= 7'h7F;
            an_s1_q    <= '1;
            an_s2_q    <= '1;
            prev_q     <= '1;
            cnt_q      <= '0;
            conf_cnt_q <= '0;
            armed_q    <= 1'b1;
            mask_q     <= '0;
            digits_q   <= '0;
            valid_q    <= '0;
            frame_q    <= 1'b0;
            err_code_q <= '0;
            err_q      <= 1'b0;
        end else begin
            seg_s1_q   <= seg_i;
            seg_s2_q   <= seg_s1_q;
            an_s1_q    <= an_i;
            an_s2_q    <= an_s1_q;
            prev_q     <= sample;
            cnt_q      <= cnt_d;
            conf_cnt_q <= conf_cnt_d;
            armed_q    <= armed_d;
            mask_q     <= mask_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            frame_q    <= frame_d;
            err_code_q <= err_code_d;
            err_q      <= err_d;
        end
    end

    assign digits_o     = digits_q;
    assign valid_o      = valid_q;
    assign frame_done_o = frame_q;
    assign err_o        = err_q;
    assign err_code_o   = err_code_q;

endmodule
